// File: rtl/os_drain_pkg.sv
// rtl/os_drain_pkg.sv - shared FSM state type and word conversion helper for the result drain
package os_drain_pkg;

   // Drain sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2
   } drain_state_t;

   // Working width for conversion; accumulator words are sign-extended to this
   localparam int CONV_W = 128;

   // Outcome of converting one accumulator word to the output width
   typedef enum logic [1:0] {
      CLIP_NONE = 2'd0,
      CLIP_MAX  = 2'd1,
      CLIP_MIN  = 2'd2
   } clip_t;

   // Decides whether a word saturates high, low, or passes as a truncation
   function automatic clip_t conv_clip(input logic signed [CONV_W-1:0] w,
                                       input int                       out_w,
                                       input logic                     sat_en);
      logic signed [CONV_W-1:0] one;
      logic signed [CONV_W-1:0] lim_max;
      logic signed [CONV_W-1:0] lim_min;
      one     = 1;
      lim_max = (one <<< (out_w - 1)) - one;
      lim_min = -lim_max - one;
      conv_clip = CLIP_NONE;
      if (sat_en) begin
         if (w > lim_max)
            conv_clip = CLIP_MAX;
         else if (w < lim_min)
            conv_clip = CLIP_MIN;
      end
   endfunction

endpackage

// File: rtl/os_drain_sat.sv
// rtl/os_drain_sat.sv - converts one accumulator word to OUT_W bits (saturating when OS_DRAIN_SAT_EN is defined)
module os_drain_sat
   import os_drain_pkg::*;
#(
   parameter int WIDTH_MAC = 48,
   parameter int OUT_W     = 32
) (
   input  logic [WIDTH_MAC-1:0] din,
   output logic [OUT_W-1:0]     dout
);

`ifdef OS_DRAIN_SAT_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   localparam logic [OUT_W-1:0] MAX_WORD = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] MIN_WORD = {1'b1, {(OUT_W-1){1'b0}}};

   logic signed [CONV_W-1:0] ext;
   clip_t                    clip;

   // Sign-extend, classify, then pick the clipped limit or the low OUT_W bits
   always_comb begin
      ext  = {{(CONV_W-WIDTH_MAC){din[WIDTH_MAC-1]}}, din};
      clip = conv_clip(ext, OUT_W, SAT_EN);
      case (clip)
         CLIP_MAX: dout = MAX_WORD;
         CLIP_MIN: dout = MIN_WORD;
         default:  dout = din[OUT_W-1:0];
      endcase
   end

endmodule

// File: rtl/os_result_drain.sv
// rtl/os_result_drain.sv - snapshots the output-stationary array and streams it out row by row (option: OS_DRAIN_SAT_EN)
module os_result_drain
   import os_drain_pkg::*;
#(
   parameter int WIDTH_MAC = 48,
   parameter int X_AXIS    = 3,
   parameter int Y_AXIS    = 3,
   parameter int OUT_W     = 32,
   localparam int ROW_W    = (Y_AXIS > 1) ? $clog2(Y_AXIS) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [WIDTH_MAC-1:0] MAC_out [Y_AXIS][X_AXIS],
   input  logic                        start,
   output logic                        arr_clear,
   output logic [X_AXIS*OUT_W-1:0]     res_data,
   output logic [ROW_W-1:0]            res_row,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic                        res_last,
   output logic                        busy,
   output logic                        drop_err
);

   drain_state_t         state;
   logic [WIDTH_MAC-1:0] shadow [Y_AXIS][X_AXIS];
   logic [WIDTH_MAC-1:0] row_words [X_AXIS];
   logic [ROW_W-1:0]     row_nxt;

   assign row_nxt = res_row + 1'b1;

   // Sequencer: snapshot on start, one beat per handshake, one flush cycle, then idle
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         res_row   <= '0;
         res_valid <= 1'b0;
         res_last  <= 1'b0;
         arr_clear <= 1'b0;
         busy      <= 1'b0;
         drop_err  <= 1'b0;
         for (int r = 0; r < Y_AXIS; r++)
            for (int c = 0; c < X_AXIS; c++)
               shadow[r][c] <= '0;
      end else begin
         arr_clear <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  for (int r = 0; r < Y_AXIS; r++)
                     for (int c = 0; c < X_AXIS; c++)
                        shadow[r][c] <= MAC_out[r][c];
                  state     <= DRAIN;
                  res_row   <= '0;
                  res_valid <= 1'b1;
                  res_last  <= (Y_AXIS == 1);
                  arr_clear <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            DRAIN: begin
               if (start)
                  drop_err <= 1'b1;
               if (res_ready) begin
                  if (res_last) begin
                     state     <= FLUSH;
                     res_row   <= '0;
                     res_valid <= 1'b0;
                     res_last  <= 1'b0;
                  end else begin
                     res_row  <= row_nxt;
                     res_last <= (row_nxt == ROW_W'(Y_AXIS - 1));
                  end
               end
            end
            FLUSH: begin
               if (start)
                  drop_err <= 1'b1;
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Select the buffered row currently being presented
   always_comb begin
      for (int c = 0; c < X_AXIS; c++)
         row_words[c] = shadow[res_row][c];
   end

   for (genvar c = 0; c < X_AXIS; c++) begin : g_conv
      os_drain_sat #(
         .WIDTH_MAC (WIDTH_MAC),
         .OUT_W     (OUT_W)
      ) u_sat (
         .din  (row_words[c]),
         .dout (res_data[c*OUT_W +: OUT_W])
      );
   end

endmodule

// File: doc/os_result_drain.md
OS_RESULT_DRAIN -- requirements
Module: os_result_drain

Interface
REQ-001 Parameter WIDTH_MAC, default 48, width of each accumulator word read from the array.
REQ-002 Parameter X_AXIS, default 3, array columns (words per output beat).
REQ-003 Parameter Y_AXIS, default 3, array rows (beats per drain).
REQ-004 Parameter OUT_W, default 32, width of each output word; OUT_W <= WIDTH_MAC.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 MAC_out  input  [Y_AXIS][X_AXIS] x WIDTH_MAC  accumulator matrix from the output-stationary array, signed.
REQ-008 start  input  1  one-cycle pulse: array results are final, snapshot now.
REQ-009 arr_clear  output  1  one-cycle pulse to the array reg_clear input.
REQ-010 res_data  output  X_AXIS*OUT_W  one array row; column 0 in the LSBs.
REQ-011 res_row  output  $clog2(Y_AXIS) bits  row index of res_data.
REQ-012 res_valid  output  1  res_data, res_row and res_last valid.
REQ-013 res_ready  input  1  downstream accepts the beat.
REQ-014 res_last  output  1  high on the beat for row Y_AXIS-1.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 drop_err  output  1  sticky: a start arrived while busy.

Function
REQ-017 States: IDLE, DRAIN, FLUSH; the FSM leaves reset in IDLE.
REQ-018 IDLE with start=1 -> next edge: latch all Y_AXIS*X_AXIS words into the shadow buffer; row counter=0; go to DRAIN.
REQ-019 arr_clear is high exactly in the first cycle after the snapshot edge; start-to-arr_clear latency is 1 cycle.
REQ-020 In DRAIN, res_valid=1 and res_data = converted buffer row[res_row]; first res_valid is 1 cycle after start.
REQ-021 A handshake is a rising edge with res_valid & res_ready both high; each handshake increments res_row by 1.
REQ-022 With res_valid=1 and res_ready=0, res_data, res_row and res_last hold stable; there is no timeout.
REQ-023 A handshake with res_last=1 -> FLUSH; res_row wraps to 0; res_valid=0 in FLUSH.
REQ-024 FLUSH lasts one cycle, then IDLE; start during FLUSH counts as busy.
REQ-025 start while busy is ignored and the buffer is unchanged; drop_err sets and stays set until rst.
REQ-026 Changes on MAC_out after the snapshot do not affect the drained data.
REQ-027 Y_AXIS=1: the first beat has res_last=1.
REQ-028 Conversion without the macro: word = low OUT_W bits of the accumulator (two's-complement truncation).

Reset
REQ-029 rst=1 at any edge, including mid-drain -> state IDLE; res_valid, res_last, arr_clear, busy, drop_err, res_row = 0.
REQ-030 Reset clears the shadow buffer to 0, and no partial drain resumes afterwards.

Configuration
REQ-031 Macro OS_DRAIN_SAT_EN defined: each word saturates to the signed OUT_W range (max 2^(OUT_W-1)-1, min -2^(OUT_W-1)); otherwise REQ-028 applies.
REQ-032 The macro changes no ports and no timing; conversion is combinational on the buffer output.

Structure
REQ-033 A shared package os_drain_pkg holds the FSM state enum (IDLE/DRAIN/FLUSH) and the saturate/truncate conversion function.
REQ-034 One sub-module, os_drain_sat, converts a single word, with X_AXIS instances per row; there is no other hierarchy.

Verification
REQ-035 Reset: rst=1 for 2 cycles, inputs random -> all outputs 0, busy=0.
REQ-036 3x3 basic: MAC_out = [[18,12,6],[54,39,24],[90,66,42]], start pulse, res_ready=1 ->
  - arr_clear at cycle+1;
  - rows 0,1,2 on consecutive cycles, res_last on row 2;
  - busy drops 2 cycles after the last beat.
REQ-037 Back-pressure: res_ready low 4 cycles during row 1 -> row 1 held stable, no beat lost or duplicated.
REQ-038 Collision: start again in the 2nd DRAIN cycle with new MAC_out -> drop_err=1, drained data equal to the first snapshot.
REQ-039 Width conversion: OUT_W=32, word 48'h0001_0000_0005 and word -2^40 ->
  - with OS_DRAIN_SAT_EN: 32'h7FFF_FFFF and 32'h8000_0000;
  - without: 32'h0000_0005 and 32'h0000_0000.
REQ-040 Mid-drain reset: rst during row 1 -> res_valid=0 next cycle; a new start then drains from row 0.
